// File: rtl/key_event_ctrl_pkg.sv
// ============================================================================
// key_event_ctrl_pkg : shared FSM state codes and LED opcodes for key gestures
// Rev 1.0
// ============================================================================
`default_nettype none

package key_event_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PRESS1 = 3'd1,
    ST_HOLD   = 3'd2,
    ST_GAP    = 3'd3,
    ST_PRESS2 = 3'd4
  } key_state_e;

  typedef enum logic [1:0] {
    LED_KEEP = 2'd0,
    LED_INC  = 2'd1,
    LED_INV  = 2'd2,
    LED_CLR  = 2'd3
  } led_op_e;

  localparam logic [3:0] C_LED_RST = 4'h0;

  // Pulses are mutually exclusive; the priority order only matters for robustness.
  function automatic led_op_e pulse_op(input logic s, input logic d, input logic l);
    if (l) return LED_CLR;
    if (d) return LED_INV;
    if (s) return LED_INC;
    return LED_KEEP;
  endfunction

  function automatic logic [3:0] led_apply(input led_op_e op, input logic [3:0] led);
    case (op)
      LED_INC: return led + 4'd1;
      LED_INV: return ~led;
      LED_CLR: return C_LED_RST;
      default: return led;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/key_evt_fsm.sv
// ============================================================================
// key_evt_fsm : gesture timer + classifier FSM with registered one-cycle pulses
// Rev 1.0
// ============================================================================
`default_nettype none

module key_evt_fsm
  import key_event_ctrl_pkg::*;
#(
  parameter int unsigned LONG_CNT = 50_000_000,
  parameter int unsigned DCLK_CNT = 12_500_000,
  parameter int unsigned CNT_W    = 26
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic key_lvl_i,
  output logic short_o,
  output logic double_o,
  output logic long_o,
  output logic busy_o
);

  localparam logic [CNT_W-1:0] C_LONG_LAST = CNT_W'(LONG_CNT - 1);
  localparam logic [CNT_W-1:0] C_DCLK_LAST = CNT_W'(DCLK_CNT - 1);
  localparam logic [CNT_W-1:0] C_TMR_MAX   = {CNT_W{1'b1}};

  key_state_e       r_state;
  logic [CNT_W-1:0] r_timer;

  // Key edges are tested before timer expiry so a simultaneous edge always wins.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state  <= ST_IDLE;
      r_timer  <= '0;
      short_o  <= 1'b0;
      double_o <= 1'b0;
      long_o   <= 1'b0;
      busy_o   <= 1'b0;
    end else begin
      short_o  <= 1'b0;
      double_o <= 1'b0;
      long_o   <= 1'b0;
      if (r_timer != C_TMR_MAX) begin
        r_timer <= r_timer + 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          if (key_lvl_i) begin
            r_state <= ST_PRESS1;
            r_timer <= '0;
            busy_o  <= 1'b1;
          end
        end
        ST_PRESS1: begin
          if (!key_lvl_i) begin
            r_state <= ST_GAP;
            r_timer <= '0;
          end else if (r_timer == C_LONG_LAST) begin
            r_state <= ST_HOLD;
            r_timer <= '0;
            long_o  <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (!key_lvl_i) begin
            r_state <= ST_IDLE;
            r_timer <= '0;
            busy_o  <= 1'b0;
          end
        end
        ST_GAP: begin
          if (key_lvl_i) begin
            r_state <= ST_PRESS2;
            r_timer <= '0;
          end else if (r_timer == C_DCLK_LAST) begin
            r_state <= ST_IDLE;
            r_timer <= '0;
            short_o <= 1'b1;
            busy_o  <= 1'b0;
          end
        end
        ST_PRESS2: begin
          if (!key_lvl_i) begin
            r_state  <= ST_IDLE;
            r_timer  <= '0;
            double_o <= 1'b1;
            busy_o   <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_timer <= '0;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/key_event_ctrl.sv
// ============================================================================
// key_event_ctrl : key gesture classifier driving a 4-bit LED register
// Rev 1.0
// ============================================================================
`default_nettype none

module key_event_ctrl
  import key_event_ctrl_pkg::*;
#(
  parameter int unsigned LONG_CNT = 50_000_000,
  parameter int unsigned DCLK_CNT = 12_500_000,
  parameter int unsigned CNT_W    = 26
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       key_lvl_i,
  output logic       short_o,
  output logic       double_o,
  output logic       long_o,
  output logic       busy_o,
  output logic [3:0] led_o
);

  logic       w_short;
  logic       w_double;
  logic       w_long;
  logic [3:0] r_led;

  key_evt_fsm #(
    .LONG_CNT (LONG_CNT),
    .DCLK_CNT (DCLK_CNT),
    .CNT_W    (CNT_W)
  ) u_fsm (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .key_lvl_i (key_lvl_i),
    .short_o   (w_short),
    .double_o  (w_double),
    .long_o    (w_long),
    .busy_o    (busy_o)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_led <= C_LED_RST;
    end else begin
      r_led <= led_apply(pulse_op(w_short, w_double, w_long), r_led);
    end
  end

  assign short_o  = w_short;
  assign double_o = w_double;
  assign long_o   = w_long;
  assign led_o    = r_led;

  a_one_pulse : assert property (@(posedge clk_i) disable iff (!rst_n_i)
    $onehot0({w_short, w_double, w_long}));

endmodule

`default_nettype wire

// File: tb/tb_key_event_ctrl.sv
// ============================================================================
// tb_key_event_ctrl : directed gestures checked against a run-length gesture model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_key_event_ctrl;

  localparam int LONG_CNT = 20;
  localparam int DCLK_CNT = 8;
  localparam int CNT_W    = 26;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       key   = 1'b0;
  logic       s_o, d_o, l_o, busy;
  logic [3:0] led;

  key_event_ctrl #(
    .LONG_CNT (LONG_CNT),
    .DCLK_CNT (DCLK_CNT),
    .CNT_W    (CNT_W)
  ) dut (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .key_lvl_i (key),
    .short_o   (s_o),
    .double_o  (d_o),
    .long_o    (l_o),
    .busy_o    (busy),
    .led_o     (led)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  bit go     = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model: a gesture is the run lengths of its first press (r1), gap (g) and
  // second press (r2); pulses fire when a run crosses its threshold.
  bit         m_act;
  int         m_r1, m_g, m_r2;
  bit         e_s, e_d, e_l, e_busy;
  logic [3:0] e_led;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_act = 0; m_r1 = 0; m_g = 0; m_r2 = 0;
      e_s = 0; e_d = 0; e_l = 0; e_busy = 0; e_led = 4'h0;
    end else begin
      cyc++;
      if (e_s)      e_led = e_led + 4'd1;
      else if (e_d) e_led = ~e_led;
      else if (e_l) e_led = 4'h0;
      e_s = 0; e_d = 0; e_l = 0;
      if (!m_act) begin
        if (key) begin m_act = 1; m_r1 = 1; m_g = 0; m_r2 = 0; end
      end else if (m_r2 > 0) begin
        if (key) m_r2++;
        else begin m_act = 0; e_d = 1; end
      end else if (m_g > 0) begin
        if (key) m_r2 = 1;
        else begin
          m_g++;
          if (m_g == DCLK_CNT + 1) begin m_act = 0; e_s = 1; end
        end
      end else begin
        if (key) begin
          m_r1++;
          if (m_r1 == LONG_CNT + 1) e_l = 1;
        end else if (m_r1 > LONG_CNT) m_act = 0;
        else m_g = 1;
      end
      e_busy = m_act;
    end
  end

  int n_s = 0, n_d = 0, n_l = 0;
  int c_s = 0, c_d = 0, c_l = 0;

  initial forever begin
    @(negedge clk);
    if (rst_n && go) begin
      chk("short_o",  32'(s_o),  32'(e_s));
      chk("double_o", 32'(d_o),  32'(e_d));
      chk("long_o",   32'(l_o),  32'(e_l));
      chk("busy_o",   32'(busy), 32'(e_busy));
      chk("led_o",    32'(led),  32'(e_led));
      chk("one_pulse", 32'($countones({s_o, d_o, l_o}) <= 1), 32'd1);
    end
    if (s_o) begin n_s++; c_s = cyc; end
    if (d_o) begin n_d++; c_d = cyc; end
    if (l_o) begin n_l++; c_l = cyc; end
  end

  task automatic hold(input logic v, input int n);
    key = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_outs"}, 32'({s_o, d_o, l_o, busy}), 32'h0);
    chk({nm, "_led"},  32'(led), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    int mark, bs, bd, bl;
    #1;
    chk_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    go    = 1'b1;
    @(negedge clk);

    // Short press
    hold(1, 5);
    mark = cyc;
    hold(0, 20);
    chk("t1_n_short", 32'(n_s), 32'd1);
    chk("t1_short_lat", 32'(c_s - mark), 32'(DCLK_CNT + 1));
    chk("t1_led", 32'(led), 32'h1);

    // Double click
    hold(1, 3); hold(0, 4); hold(1, 3);
    mark = cyc;
    hold(0, 6);
    chk("t2_n_double", 32'(n_d), 32'd1);
    chk("t2_double_lat", 32'(c_d - mark), 32'd1);
    chk("t2_led", 32'(led), 32'hE);

    // Long press, no pulse on release
    mark = cyc;
    hold(1, 40);
    hold(0, 12);
    chk("t3_n_long", 32'(n_l), 32'd1);
    chk("t3_long_lat", 32'(c_l - mark), 32'(LONG_CNT + 1));
    chk("t3_no_extra", 32'(n_s + n_d), 32'd2);
    chk("t3_led", 32'(led), 32'h0);

    // 16 shorts walk the LED through 0xF and wrap
    for (int i = 0; i < 16; i++) begin
      hold(1, 5);
      hold(0, 12);
      if (i == 14) chk("t4_led_f", 32'(led), 32'hF);
    end
    chk("t4_n_short", 32'(n_s), 32'd17);
    chk("t4_led_wrap", 32'(led), 32'h0);

    // Gap boundaries: 7 zeros and 8 zeros (press on expiry) double, 9 zeros short
    bs = n_s; bd = n_d;
    hold(1, 3); hold(0, 7); hold(1, 3); hold(0, 5);
    chk("t5_gap7_double", 32'(n_d - bd), 32'd1);
    chk("t5_gap7_led", 32'(led), 32'hF);
    hold(1, 3); hold(0, 8); hold(1, 3); hold(0, 5);
    chk("t5_gap8_double", 32'(n_d - bd), 32'd2);
    chk("t5_gap8_led", 32'(led), 32'h0);
    hold(1, 3); hold(0, 9); hold(1, 3); hold(0, 12);
    chk("t5_gap9_shorts", 32'(n_s - bs), 32'd2);
    chk("t5_gap9_no_double", 32'(n_d - bd), 32'd2);
    chk("t5_led", 32'(led), 32'h2);

    // Reset while in GAP
    bs = n_s; bd = n_d; bl = n_l;
    hold(1, 3); hold(0, 4);
    chk("t6_busy_gap", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_zero("t6_rst_gap");
    @(negedge clk);
    rst_n = 1'b1;
    hold(0, 15);
    chk("t6_gap_no_pulse", 32'(n_s + n_d + n_l - bs - bd - bl), 32'd0);

    // Reset in PRESS1 with the timer one short of long expiry
    key = 1'b1;
    repeat (20) @(negedge clk);
    chk("t6_busy_p1", 32'(busy), 32'd1);
    chk("t6_no_long_yet", 32'(n_l - bl), 32'd0);
    #2 rst_n = 1'b0;
    #1 chk_zero("t6_rst_p1");
    key = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    hold(0, 30);
    chk("t6_p1_no_pulse", 32'(n_s + n_d + n_l - bs - bd - bl), 32'd0);
    chk("t6_led", 32'(led), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
